down_timer16: RTL and testbench
===============================

Name: down_timer16

Overview:
- Loadable, programmable 16-bit down-counter/timer. It counts in the opposite direction to the lab's enable-gated up-counter.
- It counts a stored value down to zero and flags terminal count.
- It supports one-shot and auto-reload (periodic) modes.
- It drives HEX/LEDR displays and generates periodic ticks for other lab blocks.

Parameters:
- WIDTH, 16, counter and load-value width in bits.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Clr  input  1  reset; asynchronous, active-high. Clears all state immediately.
- En  input  1  count enable; decrement happens only in RUN with En=1.
- Load  input  1  load strobe; captures D into both the reload register R and the count Q.
- D  input  WIDTH  load value.
- Start  input  1  re-arm strobe; restarts the count from the stored R.
- Reload  input  1  mode select: 1 = auto-reload (periodic), 0 = one-shot.
- Q  output  WIDTH  current count (registered).
- Tc  output  1  terminal-count pulse; registered, high for exactly one cycle.
- Busy  output  1  high while in RUN.
- Done  output  1  high while in EXPIRED.

Behaviour:
- Reset (Clr=1, asynchronous, any time including mid-count):
  - Q=0, R=0, Tc=0, Busy=0, Done=0, state=IDLE.
  - Outputs reflect reset without waiting for Clk.
- States: IDLE (2'b00), RUN (2'b01), EXPIRED (2'b10). Encoding 2'b11 is illegal and recovers to IDLE on the next edge with Q unchanged.
- Priority per edge: Load > Start > count.
- Load=1 (any state):
  - R<=D, Q<=D, Tc<=0.
  - If D!=0 the next state is RUN. If D==0 the next state is IDLE.
- Start=1, Load=0:
  - In IDLE or EXPIRED with R!=0: Q<=R, go to RUN.
  - With R==0: ignored.
  - In RUN: Q<=R (restart), stay in RUN, no Tc.
- RUN, En=0: Q holds, Tc=0.
- RUN, En=1, Q>1: Q<=Q-1, Tc=0.
- RUN, En=1, Q==1 (terminal edge): Tc<=1 for one cycle, then:
  - Reload=1: Q<=R, stay in RUN. The period is exactly R enabled cycles per Tc pulse.
  - Reload=0: Q<=0, go to EXPIRED.
- EXPIRED: Q holds 0, Done=1, Tc=0. Leave only via Load or Start.
- Reload may change at any time. It is sampled only on the terminal edge.
- Load coinciding with the terminal edge: Load wins, and Tc is NOT asserted on that edge.
- Arithmetic:
  - Q is unsigned modulo 2^WIDTH.
  - Q never decrements from 0; RUN never holds Q=0.
  - D=16'hFFFF counts 65535 enabled cycles to Tc.
- Latency:
  - Q, Busy and Done update on the same edge that samples the inputs.
  - Tc goes high in the cycle immediately after the terminal edge's sampling, coincident with Q showing R or 0.
- Busy = (state==RUN). Done = (state==EXPIRED). Both are decoded from registered state, with no combinational path from inputs.

Decomposition:
- Shared definitions include file:
  - state encodings IDLE, RUN, EXPIRED;
  - default WIDTH=16.
- One natural sub-module: down_count_core. It is a WIDTH-bit loadable decrementer with inputs Clk, Clr, ld, dec, d[WIDTH-1:0] and outputs q, is_one.
- The top level holds the FSM, the R register and Tc generation.

Test Plan:
- Reset mid-count: Load D=5, count 2 cycles (Q=3), assert Clr between edges -> Q=0, Busy=0, Done=0, Tc=0 immediately; Clk edges during Clr change nothing.
- One-shot: Load D=3, Reload=0, En=1 -> Q 3,2,1,0 on successive edges; Tc high one cycle with Q=0; then Done=1, Busy=0; Q stays 0 for 10 further cycles.
- Auto-reload: Load D=4, Reload=1, En=1 for 12 cycles -> Q 4,3,2,1,4,3,2,1,...; Tc pulses every 4th cycle (3 pulses); Done never asserts.
- Enable gating: Load D=2, alternate En=1,0 -> Q decrements only on En=1 edges; Tc fires after the second enabled edge only.
- Priority and edges:
  - Load D=9 on the terminal edge of a D=1 count -> Q=9, Tc stays 0.
  - Load D=0 -> IDLE, Busy=0.
  - Start with R=0 -> ignored.
  - Start in EXPIRED with R=7 -> Q=7, RUN.
- Width boundary: Load D=16'hFFFF, En=1 -> first decrement gives 16'hFFFE; Tc after exactly 65535 enabled cycles; no wrap past 0.

Source files
------------

// File: rtl/down_timer16_pkg.sv
// Shared state encodings and default width
// for the down_timer16 block.
package down_timer16_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    EXPIRED = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

endpackage

// File: rtl/down_timer16_core.sv
// Loadable decrementer that never steps
// below zero; flags a count of one.
module down_count_core
  import down_timer16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             ld,
  input  logic             dec,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             is_one
);

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end else if (dec && (q != '0)) begin
      q <= q - 1'b1;
    end
  end

  assign is_one = (q == WIDTH'(1));

endmodule

// File: rtl/down_timer16.sv
// Programmable down-timer: FSM, reload
// register and terminal-count pulse.
module down_timer16
  import down_timer16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             En,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             Start,
  input  logic             Reload,
  output logic [WIDTH-1:0] Q,
  output logic             Tc,
  output logic             Busy,
  output logic             Done
);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] ld_val;
  logic             ld;
  logic             dec;
  logic             tc_n;
  logic             is_one;
  logic             r_nz;

  assign r_nz = |r;

  always_comb begin
    state_n = state;
    ld      = 1'b0;
    ld_val  = r;
    dec     = 1'b0;
    tc_n    = 1'b0;
    if (Load) begin
      ld      = 1'b1;
      ld_val  = D;
      state_n = (|D) ? RUN : IDLE;
    end else begin
      case (state)
        IDLE, EXPIRED: begin
          if (Start && r_nz) begin
            ld      = 1'b1;
            state_n = RUN;
          end
        end
        RUN: begin
          if (Start && r_nz) begin
            ld = 1'b1;
          end else if (En) begin
            if (is_one) begin
              // terminal edge: reload or expire
              tc_n = 1'b1;
              ld   = 1'b1;
              if (!Reload) begin
                ld_val  = '0;
                state_n = EXPIRED;
              end
            end else begin
              dec = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state <= IDLE;
      r     <= '0;
      Tc    <= 1'b0;
    end else begin
      state <= state_n;
      Tc    <= tc_n;
      if (Load) r <= D;
    end
  end

  down_count_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .Clk    (Clk),
    .Clr    (Clr),
    .ld     (ld),
    .dec    (dec),
    .d      (ld_val),
    .q      (Q),
    .is_one (is_one)
  );

  assign Busy = (state == RUN);
  assign Done = (state == EXPIRED);

endmodule

// File: tb/tb_down_timer16.sv
// Directed scoreboard bench for down_timer16.
// Expectations are queued before each edge and compared after it.
module tb_down_timer16;

  logic        Clk;
  logic        Clr;
  logic        En;
  logic        Load;
  logic [15:0] D;
  logic        Start;
  logic        Reload;
  logic [15:0] Q;
  logic        Tc;
  logic        Busy;
  logic        Done;

  typedef struct {
    string       tag;
    logic [15:0] q;
    logic        tc;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  down_timer16 dut (
    .Clk    (Clk),
    .Clr    (Clr),
    .En     (En),
    .Load   (Load),
    .D      (D),
    .Start  (Start),
    .Reload (Reload),
    .Q      (Q),
    .Tc     (Tc),
    .Busy   (Busy),
    .Done   (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic push(input string tag, input logic [15:0] q,
                      input logic tc, input logic busy, input logic done);
    exp_t e;
    e.tag  = tag;
    e.q    = q;
    e.tc   = tc;
    e.busy = busy;
    e.done = done;
    exp_q.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    e = exp_q.pop_front();
    checks++;
    assert (Q === e.q) else begin
      errors++;
      $error("FAIL %s Q got=%h exp=%h", e.tag, Q, e.q);
    end
    checks++;
    assert (Tc === e.tc) else begin
      errors++;
      $error("FAIL %s Tc got=%b exp=%b", e.tag, Tc, e.tc);
    end
    checks++;
    assert (Busy === e.busy) else begin
      errors++;
      $error("FAIL %s Busy got=%b exp=%b", e.tag, Busy, e.busy);
    end
    checks++;
    assert (Done === e.done) else begin
      errors++;
      $error("FAIL %s Done got=%b exp=%b", e.tag, Done, e.done);
    end
  endtask

  task automatic cyc(input string tag, input logic [15:0] q,
                     input logic tc, input logic busy, input logic done);
    push(tag, q, tc, busy, done);
    @(posedge Clk);
    #1;
    compare();
  endtask

  task automatic idle_in();
    Load  = 1'b0;
    Start = 1'b0;
  endtask

  initial begin
    int tc_early;
    Clr = 1'b1; En = 1'b0; Load = 1'b0;
    D = '0; Start = 1'b0; Reload = 1'b0;
    #2;
    push("reset", 16'd0, 1'b0, 1'b0, 1'b0);
    compare();
    @(negedge Clk);
    Clr = 1'b0;

    // reset mid-count
    Load = 1'b1; D = 16'd5; En = 1'b1;
    cyc("mid_load", 16'd5, 1'b0, 1'b1, 1'b0);
    idle_in();
    cyc("mid_c1", 16'd4, 1'b0, 1'b1, 1'b0);
    cyc("mid_c2", 16'd3, 1'b0, 1'b1, 1'b0);
    #2;
    Clr = 1'b1;
    #1;
    push("clr_async", 16'd0, 1'b0, 1'b0, 1'b0);
    compare();
    Load = 1'b1; D = 16'd8;
    cyc("clr_hold1", 16'd0, 1'b0, 1'b0, 1'b0);
    cyc("clr_hold2", 16'd0, 1'b0, 1'b0, 1'b0);
    idle_in();
    @(negedge Clk);
    Clr = 1'b0;

    // one-shot
    Load = 1'b1; D = 16'd3; Reload = 1'b0; En = 1'b1;
    cyc("os_load", 16'd3, 1'b0, 1'b1, 1'b0);
    idle_in();
    cyc("os_2", 16'd2, 1'b0, 1'b1, 1'b0);
    cyc("os_1", 16'd1, 1'b0, 1'b1, 1'b0);
    cyc("os_tc", 16'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++)
      cyc("os_hold", 16'd0, 1'b0, 1'b0, 1'b1);

    // auto-reload
    Load = 1'b1; D = 16'd4; Reload = 1'b1; En = 1'b1;
    cyc("ar_load", 16'd4, 1'b0, 1'b1, 1'b0);
    idle_in();
    for (int i = 0; i < 12; i++) begin
      if ((i % 4) == 3)
        cyc("ar_tc", 16'd4, 1'b1, 1'b1, 1'b0);
      else
        cyc("ar_cnt", 16'(3 - (i % 4)), 1'b0, 1'b1, 1'b0);
    end

    // enable gating
    Load = 1'b1; D = 16'd2; Reload = 1'b0; En = 1'b0;
    cyc("en_load", 16'd2, 1'b0, 1'b1, 1'b0);
    idle_in();
    En = 1'b1; cyc("en_on1", 16'd1, 1'b0, 1'b1, 1'b0);
    En = 1'b0; cyc("en_off1", 16'd1, 1'b0, 1'b1, 1'b0);
    En = 1'b1; cyc("en_tc", 16'd0, 1'b1, 1'b0, 1'b1);
    En = 1'b0; cyc("en_after", 16'd0, 1'b0, 1'b0, 1'b1);

    // Load beats the terminal edge
    Load = 1'b1; D = 16'd1; En = 1'b1;
    cyc("pri_load1", 16'd1, 1'b0, 1'b1, 1'b0);
    D = 16'd9;
    cyc("pri_load9", 16'd9, 1'b0, 1'b1, 1'b0);
    D = 16'd0;
    cyc("pri_load0", 16'd0, 1'b0, 1'b0, 1'b0);
    Load = 1'b0; Start = 1'b1;
    cyc("start_r0", 16'd0, 1'b0, 1'b0, 1'b0);

    // Start from EXPIRED and restart in RUN
    Start = 1'b0; Load = 1'b1; D = 16'd7;
    cyc("ex_load", 16'd7, 1'b0, 1'b1, 1'b0);
    idle_in();
    for (int i = 6; i >= 1; i--)
      cyc("ex_cnt", 16'(i), 1'b0, 1'b1, 1'b0);
    cyc("ex_tc", 16'd0, 1'b1, 1'b0, 1'b1);
    Start = 1'b1;
    cyc("ex_start", 16'd7, 1'b0, 1'b1, 1'b0);
    Start = 1'b0;
    cyc("rs_cnt", 16'd6, 1'b0, 1'b1, 1'b0);
    Start = 1'b1;
    cyc("rs_restart", 16'd7, 1'b0, 1'b1, 1'b0);
    Start = 1'b0;

    // Start on the terminal edge restarts without Tc
    Load = 1'b1; D = 16'd1;
    cyc("st_load1", 16'd1, 1'b0, 1'b1, 1'b0);
    Load = 1'b0; Start = 1'b1;
    cyc("st_term", 16'd1, 1'b0, 1'b1, 1'b0);
    Start = 1'b0;
    cyc("st_tc", 16'd0, 1'b1, 1'b0, 1'b1);

    // width boundary
    Load = 1'b1; D = 16'hFFFF; En = 1'b1;
    cyc("w_load", 16'hFFFF, 1'b0, 1'b1, 1'b0);
    idle_in();
    cyc("w_first", 16'hFFFE, 1'b0, 1'b1, 1'b0);
    tc_early = 0;
    for (int i = 0; i < 65533; i++) begin
      @(posedge Clk);
      #1;
      if (Tc !== 1'b0) tc_early++;
    end
    checks++;
    assert (tc_early == 0) else begin
      errors++;
      $error("FAIL w_early Tc pulses got=%0d exp=0", tc_early);
    end
    push("w_pre", 16'd1, 1'b0, 1'b1, 1'b0);
    compare();
    cyc("w_tc", 16'd0, 1'b1, 1'b0, 1'b1);
    cyc("w_nowrap", 16'd0, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
